// File: rtl/keypad_pkg.sv
// Shared keypad types and the row/column-to-keycode map for a 4x3 matrix pad.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam logic [3:0] ROW_IDLE = 4'b1110;
   localparam logic [3:0] KEY_NONE = 4'hF;

   // col_pat is cols[3:1], active low; anything but exactly one low maps to KEY_NONE.
   function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [2:0] col_pat);
      logic [1:0] col_idx;
      logic       hit;
      logic [3:0] code;
      col_idx = 2'd0;
      hit     = 1'b1;
      case (col_pat)
         3'b110:  col_idx = 2'd0;
         3'b101:  col_idx = 2'd1;
         3'b011:  col_idx = 2'd2;
         default: hit = 1'b0;
      endcase
      if (!hit) begin
         code = KEY_NONE;
      end else if (row_idx == 2'd3) begin
         case (col_idx)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad front end: one key_valid pulse per debounced press.
// key_valid fires DEBOUNCE_CYCLES cycles after the scan locks onto a contact; no flow control.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic [3:0] keycode,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic              unused_col0;
   logic [2:0]        cols_s1_q, cols_s2_q;
   state_t            state_q, state_d;
   logic [1:0]        row_idx_q, row_idx_d;
   logic [3:0]        rows_q, rows_d;
   logic [2:0]        col_lat_q, col_lat_d;
   logic [3:0]        keycode_q, keycode_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic              scan_clr, scan_inc, deb_clr, deb_inc;
   logic [2:0]        col_pat;

   assign unused_col0 = cols[0];
   assign col_pat     = cols_s2_q;

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      col_lat_d   = col_lat_q;
      keycode_d   = keycode_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      scan_clr    = 1'b0;
      scan_inc    = 1'b0;
      deb_clr     = 1'b0;
      deb_inc     = 1'b0;
      case (state_q)
         SCAN: begin
            if (scan_cnt_q == SCAN_LAST) begin
               scan_clr = 1'b1;
               if (key_map(row_idx_q, col_pat) != KEY_NONE) begin
                  state_d   = DEBOUNCE;
                  col_lat_d = col_pat;
                  deb_clr   = 1'b1;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end else begin
               scan_inc = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (col_pat != col_lat_q) begin
               state_d   = SCAN;
               row_idx_d = row_idx_q + 2'd1;
               scan_clr  = 1'b1;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d     = HELD;
               keycode_d   = key_map(row_idx_q, col_lat_q);
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
               deb_clr     = 1'b1;
            end else begin
               deb_inc = 1'b1;
            end
         end
         HELD: begin
            // Any low column, including a second key on the frozen row, restarts release timing.
            if (col_pat != 3'b111) begin
               deb_clr = 1'b1;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d    = SCAN;
               key_held_d = 1'b0;
               row_idx_d  = row_idx_q + 2'd1;
               scan_clr   = 1'b1;
               deb_clr    = 1'b1;
            end else begin
               deb_inc = 1'b1;
            end
         end
         default: begin
            state_d  = SCAN;
            scan_clr = 1'b1;
            deb_clr  = 1'b1;
         end
      endcase
      rows_d = ~(4'b0001 << row_idx_d);
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q;
      if (scan_clr) begin
         scan_cnt_d = '0;
      end else if (scan_inc && (scan_cnt_q != SCAN_LAST)) begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end
      deb_cnt_d = deb_cnt_q;
      if (deb_clr) begin
         deb_cnt_d = '0;
      end else if (deb_inc && (deb_cnt_q != DEB_LAST)) begin
         deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cols_s1_q   <= 3'b111;
         cols_s2_q   <= 3'b111;
         state_q     <= SCAN;
         row_idx_q   <= 2'd0;
         rows_q      <= ROW_IDLE;
         col_lat_q   <= 3'b111;
         keycode_q   <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         scan_cnt_q  <= '0;
         deb_cnt_q   <= '0;
      end else begin
         cols_s1_q   <= cols[3:1];
         cols_s2_q   <= cols_s1_q;
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         rows_q      <= rows_d;
         col_lat_q   <= col_lat_d;
         keycode_q   <= keycode_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         scan_cnt_q  <= scan_cnt_d;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   assign rows      = rows_q;
   assign keycode   = keycode_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: matrix model with bounce, scoreboard of expected keycodes.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SD = 4;
   localparam int DC = 8;
   localparam logic [3:0] CODE_TAB [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                            4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  cols, rows, keycode;
   logic        key_valid, key_held;
   logic [11:0] key_down = '0;
   logic        prev_valid = 1'b0;
   logic [3:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          pulse_count = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .cols     (cols),
      .rows     (rows),
      .keycode  (keycode),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      cols = 4'b1110;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (key_down[r*3+c] && !rows[r]) cols[c+1] = 1'b0;
   end

   task automatic tick();
      logic [3:0] exp;
      @(negedge clk);
      if (!reset && key_valid) begin
         pulse_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: keycode=%0d, scoreboard empty", keycode);
         end else begin
            exp = exp_q.pop_front();
            if (keycode !== exp) begin
               errors++;
               $display("FAIL keycode: got %0d expected %0d", keycode, exp);
            end
         end
         checks++;
         if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL held_with_valid: key_held=%b expected 1", key_held);
         end
         checks++;
         if (prev_valid) begin
            errors++;
            $display("FAIL valid_width: key_valid high 2 cycles, expected 1");
         end
      end
      prev_valid = key_valid;
   endtask

   task automatic wait_pulse(input int budget, output bit ok);
      int start;
      start = pulse_count;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (pulse_count != start) ok = 1'b1;
      end
   endtask

   task automatic wait_held_low(input int budget, output bit ok);
      ok = (key_held === 1'b0);
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (key_held === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic wait_rows(input logic [3:0] want, input bit equal, output bit ok);
      ok = ((rows === want) == equal);
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if ((rows === want) == equal) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_rows;
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b expected 1110", rows); end
      checks++; if (keycode !== 4'd0) begin errors++; $display("FAIL reset_keycode: got %0d expected 0", keycode); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_rows = 4'b1111 ^ (4'b0001 << ((k / SD) % 4));
         checks++;
         if (rows !== exp_rows) begin
            errors++;
            $display("FAIL rotate_%0d: rows=%b expected %b", k, rows, exp_rows);
         end
      end
   endtask

   task automatic test_clean_press();
      bit ok;
      int k;
      int start;
      start = pulse_count;
      wait_rows(4'b1110, 1'b1, ok);
      key_down[4] = 1'b1;
      exp_q.push_back(4'd5);
      wait_rows(4'b1101, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clean_row1: rows=%b never reached 1101", rows); end
      k = 0;
      while (pulse_count == start && k < 40) begin
         tick();
         k++;
      end
      checks++;
      if (k != SD + DC) begin
         errors++;
         $display("FAIL clean_latency: pulse after %0d cycles expected %0d", k, SD + DC);
      end
      repeat (5) tick();
      checks++; if (rows !== 4'b1101) begin errors++; $display("FAIL clean_frozen: rows=%b expected 1101", rows); end
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL clean_held: got %b expected 1", key_held); end
      key_down[4] = 1'b0;
      repeat (9) tick();
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early: key_held=%b expected 1", key_held); end
      tick();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_done: key_held=%b expected 0", key_held); end
      checks++; if (rows !== 4'b1011) begin errors++; $display("FAIL resume_row: rows=%b expected 1011", rows); end
      checks++; if (pulse_count != start + 1) begin errors++; $display("FAIL clean_count: %0d pulses expected 1", pulse_count - start); end
   endtask

   task automatic test_keymap();
      bit ok;
      for (int i = 0; i < 12; i++) begin
         key_down[i] = 1'b1;
         exp_q.push_back(CODE_TAB[i]);
         wait_pulse(60, ok);
         checks++; if (!ok) begin errors++; $display("FAIL keymap_timeout_%0d: no pulse, expected code %0d", i, CODE_TAB[i]); end
         key_down[i] = 1'b0;
         wait_held_low(30, ok);
         checks++; if (!ok) begin errors++; $display("FAIL keymap_release_%0d: key_held=%b expected 0", i, key_held); end
         repeat (2) tick();
      end
   endtask

   task automatic test_bounce();
      bit ok;
      int start;
      start = pulse_count;
      exp_q.push_back(4'd11);
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) key_down[11] = ~key_down[11];
         tick();
      end
      key_down[11] = 1'b1;
      checks++; if (pulse_count != start) begin errors++; $display("FAIL bounce_quiet: %0d pulses expected 0", pulse_count - start); end
      wait_pulse(60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bounce_timeout: no pulse, expected 1"); end
      repeat (30) tick();
      checks++; if (pulse_count != start + 1) begin errors++; $display("FAIL bounce_count: %0d pulses expected 1", pulse_count - start); end
      key_down[11] = 1'b0;
      wait_held_low(30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bounce_release: key_held=%b expected 0", key_held); end
   endtask

   task automatic test_held_second_key();
      bit ok;
      int start;
      int drops;
      start = pulse_count;
      drops = 0;
      key_down[0] = 1'b1;
      exp_q.push_back(4'd1);
      wait_pulse(60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL held_timeout: no pulse for key 1"); end
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc == 50) begin key_down[8] = 1'b1; key_down[2] = 1'b1; end
         if (cyc == 150) key_down[0] = 1'b0;
         tick();
         if (key_held !== 1'b1) drops++;
      end
      checks++; if (drops != 0) begin errors++; $display("FAIL held_level: key_held low %0d cycles expected 0", drops); end
      checks++; if (pulse_count != start + 1) begin errors++; $display("FAIL held_count: %0d pulses expected 1", pulse_count - start); end
      key_down = '0;
      wait_held_low(30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL held_release: key_held=%b expected 0", key_held); end
      repeat (40) tick();
      checks++; if (pulse_count != start + 1) begin errors++; $display("FAIL held_after: %0d pulses expected 1", pulse_count - start); end
   endtask

   task automatic test_two_columns();
      int start;
      int changes;
      logic [3:0] prev_rows;
      start = pulse_count;
      changes = 0;
      key_down[0] = 1'b1;
      key_down[1] = 1'b1;
      prev_rows = rows;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (rows !== prev_rows) changes++;
         prev_rows = rows;
      end
      key_down = '0;
      checks++; if (pulse_count != start) begin errors++; $display("FAIL multi_pulse: %0d pulses expected 0", pulse_count - start); end
      checks++; if (changes != 64 / SD) begin errors++; $display("FAIL multi_rotate: %0d row steps expected %0d", changes, 64 / SD); end
   endtask

   task automatic test_reset_mid_debounce();
      bit ok;
      int start;
      start = pulse_count;
      wait_rows(4'b0111, 1'b0, ok);
      key_down[10] = 1'b1;
      wait_rows(4'b0111, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_row3: rows=%b never reached 0111", rows); end
      repeat (SD + 5) tick();
      checks++; if (rows !== 4'b0111) begin errors++; $display("FAIL abort_frozen: rows=%b expected 0111", rows); end
      reset = 1'b1;
      key_down[10] = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (40) tick();
      checks++; if (pulse_count != start) begin errors++; $display("FAIL abort_pulse: %0d pulses expected 0", pulse_count - start); end
      checks++; if (keycode !== 4'd0) begin errors++; $display("FAIL abort_keycode: got %0d expected 0", keycode); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL abort_held: got %b expected 0", key_held); end
      checks++; if (dut.state_q !== SCAN) begin errors++; $display("FAIL abort_state: got %0d expected SCAN", dut.state_q); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_keymap();
      test_bounce();
      test_held_second_key();
      test_two_columns();
      test_reset_mid_debounce();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected keys never seen, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
